// File: rtl/eth_tx_pkt_arbiter.sv
// Frame-granular fixed-priority (ARP > ICMP > UDP) arbiter onto the 64-bit MAC TX AXI-Stream.
// Define TX_ARB_FAIR_EN to add the UDP starvation guard bounded by FAIR_LIMIT.
module eth_tx_pkt_arbiter #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        tx_axis_aclk,
    input  logic        tx_axis_aresetn,
    input  logic [63:0] arp_axis_tdata,
    input  logic [7:0]  arp_axis_tkeep,
    input  logic        arp_axis_tvalid,
    input  logic        arp_axis_tlast,
    output logic        arp_axis_tready,
    input  logic [63:0] icmp_axis_tdata,
    input  logic [7:0]  icmp_axis_tkeep,
    input  logic        icmp_axis_tvalid,
    input  logic        icmp_axis_tlast,
    output logic        icmp_axis_tready,
    input  logic [63:0] udp_axis_tdata,
    input  logic [7:0]  udp_axis_tkeep,
    input  logic        udp_axis_tvalid,
    input  logic        udp_axis_tlast,
    output logic        udp_axis_tready,
    output logic [63:0] mac_tx_axis_tdata,
    output logic [7:0]  mac_tx_axis_tkeep,
    output logic        mac_tx_axis_tvalid,
    output logic        mac_tx_axis_tlast,
    input  logic        mac_tx_axis_tready,
    output logic [2:0]  arb_grant,
    output logic        arb_busy,
    output logic [15:0] arp_pkt_cnt,
    output logic [15:0] icmp_pkt_cnt,
    output logic [15:0] udp_pkt_cnt
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_grant, w_grant_nxt;
    logic [2:0]  w_vld, w_last, w_win;
    logic        w_own_vld, w_own_last, w_eof;
    logic [15:0] r_arp_cnt, r_icmp_cnt, r_udp_cnt;

    // Out-of-range limits leave this marker block in the elaborated hierarchy.
    if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_fair_limit_out_of_range
    end

    assign w_vld      = {udp_axis_tvalid, icmp_axis_tvalid, arp_axis_tvalid};
    assign w_last     = {udp_axis_tlast, icmp_axis_tlast, arp_axis_tlast};
    assign w_own_vld  = |(r_grant & w_vld);
    assign w_own_last = |(r_grant & w_last);
    assign w_eof      = (r_state == ST_BUSY) & w_own_vld & w_own_last & mac_tx_axis_tready;

`ifdef TX_ARB_FAIR_EN
    localparam logic [3:0] LP_FAIR_LIMIT = 4'(FAIR_LIMIT);
    logic [3:0] r_fair_cnt;

    always_comb begin
        w_win = 3'b000;
        if (w_vld[2] && r_fair_cnt >= LP_FAIR_LIMIT) w_win = 3'b100;
        else if (w_vld[0])                           w_win = 3'b001;
        else if (w_vld[1])                           w_win = 3'b010;
        else if (w_vld[2])                           w_win = 3'b100;
    end

    // Counts consecutive ARP/ICMP wins that bypassed a waiting UDP frame.
    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            r_fair_cnt <= 4'd0;
        end else if (r_state == ST_IDLE && |w_vld) begin
            if (w_win[2] || !w_vld[2]) r_fair_cnt <= 4'd0;
            else if (r_fair_cnt != 4'hF) r_fair_cnt <= r_fair_cnt + 4'd1;
        end
    end
`else
    always_comb begin
        w_win = 3'b000;
        if (w_vld[0])      w_win = 3'b001;
        else if (w_vld[1]) w_win = 3'b010;
        else if (w_vld[2]) w_win = 3'b100;
    end
`endif

    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            r_state <= ST_IDLE;
            r_grant <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (|w_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_win;
                end
            end
            ST_BUSY: begin
                if (w_eof) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = 3'b000;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 3'b000;
            end
        endcase
    end

    // Zero-latency mux; a cleared grant forces all-zero outputs while idle.
    always_comb begin
        mac_tx_axis_tdata  = 64'd0;
        mac_tx_axis_tkeep  = 8'd0;
        mac_tx_axis_tvalid = 1'b0;
        mac_tx_axis_tlast  = 1'b0;
        case (r_grant)
            3'b001: begin
                mac_tx_axis_tdata  = arp_axis_tdata;
                mac_tx_axis_tkeep  = arp_axis_tkeep;
                mac_tx_axis_tvalid = arp_axis_tvalid;
                mac_tx_axis_tlast  = arp_axis_tlast;
            end
            3'b010: begin
                mac_tx_axis_tdata  = icmp_axis_tdata;
                mac_tx_axis_tkeep  = icmp_axis_tkeep;
                mac_tx_axis_tvalid = icmp_axis_tvalid;
                mac_tx_axis_tlast  = icmp_axis_tlast;
            end
            3'b100: begin
                mac_tx_axis_tdata  = udp_axis_tdata;
                mac_tx_axis_tkeep  = udp_axis_tkeep;
                mac_tx_axis_tvalid = udp_axis_tvalid;
                mac_tx_axis_tlast  = udp_axis_tlast;
            end
            default: ;
        endcase
    end

    assign arp_axis_tready  = r_grant[0] & mac_tx_axis_tready;
    assign icmp_axis_tready = r_grant[1] & mac_tx_axis_tready;
    assign udp_axis_tready  = r_grant[2] & mac_tx_axis_tready;

    always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
        if (!tx_axis_aresetn) begin
            r_arp_cnt  <= 16'd0;
            r_icmp_cnt <= 16'd0;
            r_udp_cnt  <= 16'd0;
        end else if (w_eof) begin
            if (r_grant[0]) r_arp_cnt  <= r_arp_cnt + 16'd1;
            if (r_grant[1]) r_icmp_cnt <= r_icmp_cnt + 16'd1;
            if (r_grant[2]) r_udp_cnt  <= r_udp_cnt + 16'd1;
        end
    end

    assign arb_grant    = r_grant;
    assign arb_busy     = (r_state == ST_BUSY);
    assign arp_pkt_cnt  = r_arp_cnt;
    assign icmp_pkt_cnt = r_icmp_cnt;
    assign udp_pkt_cnt  = r_udp_cnt;
endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// Bench for eth_tx_pkt_arbiter: sources are beat queues, a frame-level reference predicts owner/outputs.
// Honours TX_ARB_FAIR_EN in its reference when the design is built with it.
module tb_eth_tx_pkt_arbiter;
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] s_data [3];
    logic [7:0]  s_keep [3];
    logic        s_valid [3];
    logic        s_last [3];
    logic        mac_rdy;
    logic        arp_rdy, icmp_rdy, udp_rdy;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_valid, m_last, arb_busy;
    logic [2:0]  arb_grant;
    logic [15:0] arp_cnt, icmp_cnt, udp_cnt;

    always #5 clk = ~clk;

    eth_tx_pkt_arbiter #(.FAIR_LIMIT(4)) dut (
        .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n),
        .arp_axis_tdata(s_data[0]), .arp_axis_tkeep(s_keep[0]),
        .arp_axis_tvalid(s_valid[0]), .arp_axis_tlast(s_last[0]), .arp_axis_tready(arp_rdy),
        .icmp_axis_tdata(s_data[1]), .icmp_axis_tkeep(s_keep[1]),
        .icmp_axis_tvalid(s_valid[1]), .icmp_axis_tlast(s_last[1]), .icmp_axis_tready(icmp_rdy),
        .udp_axis_tdata(s_data[2]), .udp_axis_tkeep(s_keep[2]),
        .udp_axis_tvalid(s_valid[2]), .udp_axis_tlast(s_last[2]), .udp_axis_tready(udp_rdy),
        .mac_tx_axis_tdata(m_data), .mac_tx_axis_tkeep(m_keep),
        .mac_tx_axis_tvalid(m_valid), .mac_tx_axis_tlast(m_last), .mac_tx_axis_tready(mac_rdy),
        .arb_grant(arb_grant), .arb_busy(arb_busy),
        .arp_pkt_cnt(arp_cnt), .icmp_pkt_cnt(icmp_cnt), .udp_pkt_cnt(udp_cnt)
    );

    // Reference state: which source owns the link (-1 = none) and frames forwarded per source.
    beat_t       q [3][$];
    bit          mid [3];
    int          owner = -1;
    logic [15:0] m_cnt [3];
    int          fair = 0;
    int          gap_pct = 0;
    int          rdy_pct = 100;
    int          glog[$];
    logic [2:0]  prev_grant = 3'b000;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gidx(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    // Priority ARP > ICMP > UDP; with the guard, a UDP frame that has been passed over
    // FAIR_LIMIT times in a row wins the next decision.
    function automatic int pick(input logic [2:0] dv);
        int w;
        w = dv[0] ? 0 : (dv[1] ? 1 : 2);
`ifdef TX_ARB_FAIR_EN
        if (dv[2] && fair >= 4) w = 2;
        if (w != 2 && dv[2]) fair = (fair < 15) ? fair + 1 : 15;
        else fair = 0;
`endif
        return w;
    endfunction

    task automatic add_frame(input int s, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom};
            b.k = (i == n - 1) ? 8'($urandom_range(255, 1)) : 8'hFF;
            b.l = (i == n - 1);
            q[s].push_back(b);
        end
    endtask

    task automatic cycle();
        logic [2:0]  dv;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        ev, el;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            dv[s] = (q[s].size() > 0) && (!mid[s] || int'($urandom_range(99)) >= gap_pct);
            s_valid[s] = dv[s];
            if (dv[s]) begin
                s_data[s] = q[s][0].d;
                s_keep[s] = q[s][0].k;
                s_last[s] = q[s][0].l;
            end else begin
                s_data[s] = {$urandom, $urandom};
                s_keep[s] = 8'($urandom);
                s_last[s] = 1'($urandom);
            end
        end
        mac_rdy = int'($urandom_range(99)) < rdy_pct;
        #1;
        ed = 64'd0; ek = 8'd0; ev = 1'b0; el = 1'b0;
        if (owner >= 0) begin
            ed = s_data[owner]; ek = s_keep[owner]; ev = s_valid[owner]; el = s_last[owner];
        end
        chk("mac_tdata", m_data, ed);
        chk("mac_tkeep", {56'd0, m_keep}, {56'd0, ek});
        chk("mac_tvalid_tlast", {m_valid, m_last}, {ev, el});
        chk("treadys", {udp_rdy, icmp_rdy, arp_rdy},
            (owner >= 0 && mac_rdy) ? (3'b001 << owner) : 3'b000);
        chk("arb_grant", arb_grant, (owner >= 0) ? (3'b001 << owner) : 3'b000);
        chk("arb_busy", arb_busy, owner >= 0);
        chk("pkt_cnt", {arp_cnt, icmp_cnt, udp_cnt}, {m_cnt[0], m_cnt[1], m_cnt[2]});
        if (arb_grant != 3'b000 && prev_grant == 3'b000) glog.push_back(gidx(arb_grant));
        prev_grant = arb_grant;
        @(posedge clk);
        if (owner >= 0) begin
            if (dv[owner] && mac_rdy) begin
                el = q[owner][0].l;
                void'(q[owner].pop_front());
                mid[owner] = 1'b1;
                if (el) begin
                    m_cnt[owner] = m_cnt[owner] + 16'd1;
                    mid[owner] = 1'b0;
                    owner = -1;
                end
            end
        end else if (dv != 3'b000) begin
            owner = pick(dv);
        end
    endtask

    task automatic drain(input int maxc);
        int  n;
        bit  done;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() != 0 || owner >= 0) && n < maxc) begin
            cycle();
            n++;
        end
        done = (q[0].size() + q[1].size() + q[2].size() == 0) && owner < 0;
        chk("drain_timeout", done, 1);
        cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mac_ctl", {m_valid, m_last, m_keep}, 0);
        chk("rst_mac_tdata", m_data, 0);
        chk("rst_treadys", {udp_rdy, icmp_rdy, arp_rdy}, 0);
        chk("rst_grant_busy", {arb_grant, arb_busy}, 0);
        chk("rst_pkt_cnt", {arp_cnt, icmp_cnt, udp_cnt}, 0);
        for (int s = 0; s < 3; s++) begin
            q[s].delete();
            mid[s] = 1'b0;
            m_cnt[s] = 16'd0;
            s_valid[s] = 1'b0;
        end
        owner = -1;
        fair = 0;
        prev_grant = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_order(input string tag, input int e[$]);
        chk({tag, "_len"}, glog.size(), e.size());
        foreach (e[i]) chk(tag, (i < glog.size()) ? glog[i] : -1, e[i]);
    endtask

    initial begin
        int e[$];
        for (int s = 0; s < 3; s++) begin
            s_data[s] = 64'd0; s_keep[s] = 8'd0; s_valid[s] = 1'b0; s_last[s] = 1'b0;
            m_cnt[s] = 16'd0; mid[s] = 1'b0;
        end
        mac_rdy = 1'b1;
        do_reset();

        // Single 3-beat UDP frame, link always ready.
        glog.delete();
        add_frame(2, 3);
        drain(20);
        e.delete(); e.push_back(2);
        chk_order("udp_only_order", e);
        chk("udp_only_cnt", udp_cnt, 16'd1);

        // All three sources valid in the same idle cycle.
        glog.delete();
        add_frame(0, 2); add_frame(1, 2); add_frame(2, 2);
        drain(40);
        e.delete(); e.push_back(0); e.push_back(1); e.push_back(2);
        chk_order("prio_order", e);

        // ICMP arriving mid-way through an 8-beat UDP frame must wait.
        glog.delete();
        add_frame(2, 8);
        for (int i = 0; i < 3; i++) cycle();
        add_frame(1, 2);
        drain(40);
        e.delete(); e.push_back(2); e.push_back(1);
        chk_order("no_preempt_order", e);

        // Backpressure and source gaps mid-frame.
        gap_pct = 40; rdy_pct = 50;
        add_frame(0, 5); add_frame(2, 6); add_frame(1, 1);
        drain(300);
        gap_pct = 0; rdy_pct = 100;

        // Reset in the middle of an ICMP frame, then a fresh ARP frame.
        add_frame(1, 6);
        for (int i = 0; i < 20 && q[1].size() > 4; i++) cycle();
        do_reset();
        add_frame(0, 2);
        drain(20);
        chk("post_rst_arp_cnt", arp_cnt, 16'd1);
        chk("post_rst_icmp_cnt", icmp_cnt, 16'd0);

        // ICMP continuously valid while UDP waits.
        do_reset();
        glog.delete();
        for (int i = 0; i < 12; i++) add_frame(1, 1);
        add_frame(2, 2); add_frame(2, 2);
        drain(100);
        e.delete();
`ifdef TX_ARB_FAIR_EN
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) e.push_back(1);
            e.push_back(2);
        end
        for (int i = 0; i < 4; i++) e.push_back(1);
`else
        for (int i = 0; i < 12; i++) e.push_back(1);
        e.push_back(2); e.push_back(2);
`endif
        chk_order("fair_order", e);

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            int ncyc;
            gap_pct = $urandom_range(50);
            rdy_pct = $urandom_range(100, 30);
            if ($urandom_range(1) == 1) add_frame($urandom_range(2), $urandom_range(6, 1));
            if ($urandom_range(2) == 0) add_frame($urandom_range(2), $urandom_range(6, 1));
            ncyc = $urandom_range(20, 1);
            for (int i = 0; i < ncyc; i++) cycle();
        end
        drain(3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
